// File: rtl/proj_serial_divider_n.sv
// Multi-cycle radix-2 restoring divider behind a Wishbone slave register block.
// Supports signed/unsigned modes, RISC-V style div-by-zero/overflow results and blinky pads.
module proj_serial_divider_n #(
  parameter int               WBW       = 32,
  parameter int               LAW       = 32,
  parameter int               XLEN      = 32,
  parameter logic [WBW-1:0]   BASE_ADDR = 32'h3000_0000,
  parameter int               BLINK_W   = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [WBW/8-1:0]   wbs_sel_i,
  input  logic [WBW-1:0]     wbs_adr_i,
  input  logic [WBW-1:0]     wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [WBW-1:0]     wbs_dat_o,
  output logic [LAW-1:0]     la_data_o,
  output logic               hw_blinky_o,
  output logic               sw_blinky_o
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [XLEN-1:0]     dividend, divisor;
  logic [XLEN-1:0]     quotient, remainder;
  logic [XLEN-1:0]     acc, q, mag_b_q;
  logic                neg_a_q, neg_q_q;
  logic                signed_mode, sw_blink, done, div_by_zero, overflow;
  logic [BLINK_W-1:0]  blink_cnt;

  logic                busy, wb_go, hit, wr;
  logic [5:0]          word;
  logic [WBW-1:0]      be_mask, rdata;
  logic [XLEN-1:0]     wmask, dividend_next, divisor_next;
  logic                neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       shifted, trial;
  logic                trial_ok;
  logic                start_ok;

  assign busy  = (state != S_IDLE);
  assign wb_go = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
  assign hit   = (wbs_adr_i[WBW-1:8] == BASE_ADDR[WBW-1:8]) && (wbs_adr_i[1:0] == 2'b00);
  assign word  = wbs_adr_i[7:2];
  assign wr    = wb_go && wbs_we_i && hit;
  assign start_ok = wr && (word == 6'd2) && wbs_sel_i[0] && wbs_dat_i[0] && !busy;

  // NOTE: combinational blocks assign every output up front so no path leaves a latch.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < WBW; b++) be_mask[b] = wbs_sel_i[b/8];
    wmask         = be_mask[XLEN-1:0];
    dividend_next = (dividend & ~wmask) | (wbs_dat_i[XLEN-1:0] & wmask);
    divisor_next  = (divisor  & ~wmask) | (wbs_dat_i[XLEN-1:0] & wmask);

    rdata = '0;
    if (hit) begin
      case (word)
        6'd0:    rdata = WBW'(dividend);
        6'd1:    rdata = WBW'(divisor);
        6'd2:    rdata = WBW'({overflow, div_by_zero, done, sw_blink, signed_mode, busy});
        6'd3:    rdata = WBW'(quotient);
        6'd4:    rdata = WBW'(remainder);
        default: rdata = '0;
      endcase
    end
  end

  // Operand magnitudes and the restoring trial subtraction for one quotient bit.
  always_comb begin
    neg_a    = signed_mode && dividend[XLEN-1];
    neg_b    = signed_mode && divisor[XLEN-1];
    mag_a    = neg_a ? -dividend : dividend;
    mag_b    = neg_b ? -divisor  : divisor;
    shifted  = {acc, q[XLEN-1]};
    trial    = shifted - {1'b0, mag_b_q};
    trial_ok = !trial[XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      count       <= '0;
      dividend    <= '0;
      divisor     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      acc         <= '0;
      q           <= '0;
      mag_b_q     <= '0;
      neg_a_q     <= 1'b0;
      neg_q_q     <= 1'b0;
      signed_mode <= 1'b0;
      sw_blink    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
    end else begin
      wbs_ack_o <= wb_go;
      wbs_dat_o <= (wb_go && !wbs_we_i) ? rdata : '0;

      if (wr && word == 6'd0 && !busy) dividend <= dividend_next;
      if (wr && word == 6'd1 && !busy) divisor  <= divisor_next;
      if (wr && word == 6'd2 && wbs_sel_i[0]) begin
        sw_blink <= wbs_dat_i[2];
        if (!busy)        signed_mode <= wbs_dat_i[1];
        if (wbs_dat_i[3]) done        <= 1'b0;
      end

      // FSM sits after the register writes so a done set in DONE wins over clr_done.
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= S_PREP;
          end
        end
        S_PREP: begin
          if (divisor == '0) begin
            q           <= '1;
            acc         <= dividend;
            div_by_zero <= 1'b1;
            state       <= S_DONE;
          end else if (signed_mode && dividend == MIN_INT && divisor == '1) begin
            q        <= MIN_INT;
            acc      <= '0;
            overflow <= 1'b1;
            state    <= S_DONE;
          end else begin
            q       <= mag_a;
            acc     <= '0;
            mag_b_q <= mag_b;
            neg_a_q <= neg_a;
            neg_q_q <= neg_a ^ neg_b;
            count   <= CNT_W'(XLEN-1);
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= trial_ok ? trial[XLEN-1:0] : shifted[XLEN-1:0];
          q   <= {q[XLEN-2:0], trial_ok};
          if (count == '0) state <= S_FIX;
          else             count <= count - CNT_W'(1);
        end
        S_FIX: begin
          if (neg_q_q) q   <= -q;
          if (neg_a_q) acc <= -acc;
          state <= S_DONE;
        end
        S_DONE: begin
          quotient  <= q;
          remainder <= acc;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) blink_cnt <= '0;
    else         blink_cnt <= blink_cnt + BLINK_W'(1);
  end

  assign hw_blinky_o = blink_cnt[BLINK_W-1];
  assign sw_blinky_o = sw_blink;
  assign la_data_o   = LAW'(quotient);

endmodule

// File: tb/tb_proj_serial_divider_n.sv
// Randomised and directed bench for proj_serial_divider_n against a plain-arithmetic
// reference model of the divide results, flags and register map.
module tb_proj_serial_divider_n;

  localparam logic [31:0] BASE       = 32'h3000_0000;
  localparam logic [31:0] A_DIVIDEND = BASE + 32'h00;
  localparam logic [31:0] A_DIVISOR  = BASE + 32'h04;
  localparam logic [31:0] A_CTRL     = BASE + 32'h08;
  localparam logic [31:0] A_QUOT     = BASE + 32'h0C;
  localparam logic [31:0] A_REM      = BASE + 32'h10;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] la_data_o;
  logic        hw_blinky_o, sw_blinky_o;

  int checks   = 0;
  int failures = 0;
  bit sw_exp   = 1'b0;

  always #5 clk_i = ~clk_i;

  proj_serial_divider_n #(
    .WBW(32), .LAW(32), .XLEN(32), .BASE_ADDR(BASE), .BLINK_W(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_data_o(la_data_o), .hw_blinky_o(hw_blinky_o), .sw_blinky_o(sw_blinky_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V division semantics computed with ordinary arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                output logic [31:0] qo, output logic [31:0] ro,
                                output bit dz, output bit ov);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      qo = 32'hFFFF_FFFF; ro = a; dz = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      qo = 32'h8000_0000; ro = 32'd0; ov = 1'b1;
    end else if (sgn) begin
      qo = 32'(sa / sb); ro = 32'(sa % sb);
    end else begin
      qo = a / b; ro = a % b;
    end
  endfunction

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = addr; wbs_dat_i = data; wbs_sel_i = sel;
    @(posedge clk_i); #1;
    check("wr_ack", wbs_ack_o, 1);
    @(negedge clk_i);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = addr; wbs_sel_i = 4'hF;
    @(posedge clk_i); #1;
    check("rd_ack", wbs_ack_o, 1);
    data = wbs_dat_o;
    @(negedge clk_i);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
  endtask

  task automatic wait_done();
    logic [31:0] d;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      wb_read(A_CTRL, d);
      seen = d[3];
    end
    check("done_timeout", seen, 1);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    wb_write(A_DIVIDEND, a, 4'hF);
    wb_write(A_DIVISOR, b, 4'hF);
    wb_write(A_CTRL, {28'd0, 1'b0, sw_exp, sgn, 1'b1}, 4'hF);
  endtask

  // exp_lat > 0: count cycles from start accept until the quotient reaches la_data_o.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, input int exp_lat);
    logic [31:0] qe, re, d;
    bit dz, ov;
    int n;
    model(a, b, sgn, qe, re, dz, ov);
    start_op(a, b, sgn);
    if (exp_lat > 0) begin
      n = 0;
      do begin
        @(posedge clk_i); #1;
        n++;
      end while (la_data_o !== qe && n < 100);
      check({tag, "_latency"}, n, exp_lat);
    end else begin
      wait_done();
    end
    wb_read(A_QUOT, d); check({tag, "_quot"}, d, qe);
    wb_read(A_REM, d);  check({tag, "_rem"}, d, re);
    wb_read(A_CTRL, d); check({tag, "_ctrl"}, d, {26'd0, ov, dz, 1'b1, sw_exp, sgn, 1'b0});
  endtask

  initial begin
    logic [31:0] d, a, b;
    bit sgn;

    reset_i = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_la", la_data_o, 0);
    check("rst_sw", sw_blinky_o, 0);
    check("rst_hw", hw_blinky_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wb_read(A_CTRL, d); check("rst_ctrl", d, 0);
    wb_read(A_QUOT, d); check("rst_quot", d, 0);

    // Byte-lane merge on DIVIDEND.
    wb_write(A_DIVIDEND, 32'hAABB_CCDD, 4'hF);
    wb_write(A_DIVIDEND, 32'h1122_3344, 4'b0101);
    wb_read(A_DIVIDEND, d); check("byte_sel", d, 32'hAA22_CC44);

    // Ack is a single-cycle pulse even with strobe held.
    @(negedge clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_CTRL;
    @(posedge clk_i); #1; check("ack_p1", wbs_ack_o, 1);
    @(posedge clk_i); #1; check("ack_p2", wbs_ack_o, 0);
    @(posedge clk_i); #1; check("ack_p3", wbs_ack_o, 1);
    @(negedge clk_i);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge clk_i); #1; check("ack_p4", wbs_ack_o, 0);

    do_div("u100_7", 32'd100, 32'd7, 1'b0, 35);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 35);
    do_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 35);
    do_div("dz", 32'h0000_1234, 32'd0, 1'b0, 2);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);

    // Writes and a second start during CALC are acked but ignored.
    start_op(32'd1000, 32'd10, 1'b0);
    repeat (5) @(negedge clk_i);
    wb_write(A_DIVISOR, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'h0000_0003, 4'hF);
    wb_read(A_CTRL, d); check("mid_busy", d, 32'h1);
    wb_read(BASE + 32'h20, d); check("unmapped_rd", d, 0);
    wb_write(BASE + 32'h24, 32'hDEAD_BEEF, 4'hF);
    wait_done();
    wb_read(A_QUOT, d);    check("mid_quot", d, 32'd100);
    wb_read(A_REM, d);     check("mid_rem", d, 32'd0);
    wb_read(A_DIVISOR, d); check("mid_divisor", d, 32'd10);

    // Software blinky and clr_done.
    wb_write(A_CTRL, 32'h4, 4'hF);
    sw_exp = 1'b1;
    @(posedge clk_i); #1; check("sw_on", sw_blinky_o, 1);
    wb_read(A_CTRL, d); check("ctrl_sw", d, 32'h0C);
    wb_write(A_CTRL, 32'h8, 4'hF);
    sw_exp = 1'b0;
    wb_read(A_CTRL, d); check("clr_done", d, 32'h0);
    check("sw_off", sw_blinky_o, 0);

    // Reset during CALC with a read strobe pending.
    start_op(32'd5000, 32'd7, 1'b0);
    repeat (10) @(negedge clk_i);
    reset_i = 1'b1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_QUOT;
    @(posedge clk_i); #1;
    check("midrst_ack", wbs_ack_o, 0);
    check("midrst_la", la_data_o, 0);
    check("midrst_hw0", hw_blinky_o, 0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin
        @(negedge clk_i);
        reset_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      end
      @(posedge clk_i); #1;
      check($sformatf("hw_blink_%0d", k), hw_blinky_o, (k >> 3) & 1);
    end
    wb_read(A_CTRL, d);     check("midrst_ctrl", d, 0);
    wb_read(A_QUOT, d);     check("midrst_quot", d, 0);
    wb_read(A_DIVIDEND, d); check("midrst_dividend", d, 0);
    do_div("after_rst", 32'd9, 32'd3, 1'b0, 35);

    // Randomised operations against the reference model.
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2, 3, 4: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      do_div($sformatf("rnd%0d", i), a, b, sgn, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
